// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline stage: valid/ready handshake with a main + skid entry, branch flush,
// and saturating stall/flush statistics. All handshake outputs come straight from registers.
module id_ex_skid_stage #(
    parameter int CTRL_W    = 7,
    parameter int DATA_W    = 148,
    parameter int CNT_W     = 16,
    parameter bit ZERO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic              push, pop;
    logic [CNT_W+1:0]  flush_sum;

    // skid_valid implies main_valid, so the two bits encode 0/1/2 directly.
    assign occupancy = {main_valid & skid_valid, main_valid ^ skid_valid};
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    assign push      = in_valid & in_ready & ~flush;
    assign pop       = main_valid & out_ready;
    assign flush_sum = {2'b00, flush_cnt} + (CNT_W + 2)'(occupancy);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking would let main see the skid's new contents in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
            main_data  <= '0;
            skid_data  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
            if (ZERO_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
            flush_cnt <= (flush_sum > (CNT_W + 2)'(CNT_MAX)) ? CNT_MAX : flush_sum[CNT_W-1:0];
        end else begin
            if (main_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (skid_valid) begin
                // Full: in_ready is low, so only a pop can move things along.
                if (pop) begin
                    main_ctrl  <= skid_ctrl;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                end
            end else if (main_valid) begin
                if (push && pop) begin
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end else if (push) begin
                    skid_valid <= 1'b1;
                    skid_ctrl  <= in_ctrl;
                    skid_data  <= in_data;
                end else if (pop) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end
            end else if (push) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end
        end
    end

endmodule
